// File: rtl/delay_sched_pkg.sv
// Shared helpers for the delay scheduler: width calculation, latency clamp, reset latency.
package delay_sched_pkg;

    localparam int unsigned DEF_LAT_C = 4;

    // Bits needed to hold values 0..n-1 (minimum 1).
    function automatic int unsigned clog2_w(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

    // Force a requested latency into the legal range 1..max_lat.
    function automatic int unsigned clamp_lat(input int unsigned req, input int unsigned max_lat);
        if (req == 0) return 1;
        if (req > max_lat) return max_lat;
        return req;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head entry and occupancy count.
module sync_fifo
    import delay_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = clog2_w(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0]      count_o
);

    localparam int unsigned PTR_W = clog2_w(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  pop_eff;
    logic                  full;

    assign pop_eff = pop_i && valid_q;
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));

    // Next pointers/count and the entry that becomes the head after this edge.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        count_d  = count_q;
        if (push_i && !pop_eff) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_eff) begin
            count_d = count_q - CNT_W'(1);
        end
        valid_d = (count_d != '0);
        head_d  = head_q;
        if (valid_d) begin
            // New head is the slot being written this edge only when the FIFO drains to it.
            if (push_i && (rd_ptr_d == wr_ptr_q)) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control and head registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Upstream must never push into a full FIFO unless a pop frees a slot.
    assert property (@(posedge clk) disable iff (rst) !(push_i && full && !pop_eff));

    assign out_valid_o = valid_q;
    assign out_data_o  = head_q;
    assign count_o     = count_q;

endmodule

// File: rtl/delay_sched_ctrl.sv
// Credit-controlled variable-latency delay line feeding an output FIFO.
module delay_sched_ctrl
    import delay_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_LAT    = 32,
    parameter int unsigned DEF_LAT    = DEF_LAT_C,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LAT_W      = clog2_w(MAX_LAT + 1),
    parameter int unsigned CNT_W      = clog2_w(MAX_LAT + FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    input  logic                  cfg_lat_we,
    input  logic [LAT_W-1:0]      cfg_lat,
    output logic                  cfg_busy,
    output logic [LAT_W-1:0]      cur_lat,
    output logic [CNT_W-1:0]      inflight
);

    localparam int unsigned IDX_W  = clog2_w(MAX_LAT);
    localparam int unsigned FCNT_W = clog2_w(FIFO_DEPTH + 1);

    logic [MAX_LAT-1:0]    vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q [MAX_LAT];
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [LAT_W-1:0]      cur_lat_q, cur_lat_d;
    logic [LAT_W-1:0]      pend_lat_q, pend_lat_d;
    logic                  cfg_busy_q, cfg_busy_d;

    logic [IDX_W-1:0]      tap_idx;
    logic                  tap_vld;
    logic [DATA_WIDTH-1:0] tap_data;
    logic                  fifo_push;
    logic [FCNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]      occupancy;
    logic                  accept;

    assign tap_idx   = IDX_W'(cur_lat_q - LAT_W'(1));
    assign tap_vld   = vld_q[tap_idx];
    assign tap_data  = data_q[tap_idx];
    assign fifo_push = tap_vld && !flush;

    // Admit only when a FIFO slot is reserved for every item already committed.
    assign occupancy = CNT_W'(fifo_count) + inflight_q;
    assign in_ready  = (occupancy < CNT_W'(FIFO_DEPTH)) && !flush && !cfg_busy_q && !rst;
    assign accept    = in_valid && in_ready;

    // Next-state for stage valids, in-flight count and latency reconfiguration.
    always_comb begin
        vld_d      = '0;
        inflight_d = inflight_q;
        cur_lat_d  = cur_lat_q;
        pend_lat_d = pend_lat_q;
        cfg_busy_d = cfg_busy_q;

        // The tap consumes its item, so stages at or beyond cur_lat never hold a valid bit.
        vld_d[0] = accept;
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            vld_d[k+1] = vld_q[k] && (LAT_W'(k + 1) < cur_lat_q) && !flush;
        end

        if (flush) begin
            inflight_d = '0;
        end else if (accept && !tap_vld) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept && tap_vld) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        // Latency only changes once the delay line is empty.
        if (cfg_lat_we) begin
            pend_lat_d = LAT_W'(clamp_lat(32'(cfg_lat), MAX_LAT));
            cfg_busy_d = 1'b1;
        end else if (cfg_busy_q && (inflight_q == '0)) begin
            cur_lat_d  = pend_lat_q;
            cfg_busy_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
            cur_lat_q  <= LAT_W'(DEF_LAT);
            pend_lat_q <= LAT_W'(DEF_LAT);
            cfg_busy_q <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            cur_lat_q  <= cur_lat_d;
            pend_lat_q <= pend_lat_d;
            cfg_busy_q <= cfg_busy_d;
        end
    end

    // Payload shift; qualified by the stage valid bits.
    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int k = 1; k < MAX_LAT; k++) begin
            data_q[k] <= data_q[k-1];
        end
    end

    assert property (@(posedge clk) disable iff (rst) inflight_q <= CNT_W'(MAX_LAT + FIFO_DEPTH));
    assert property (@(posedge clk) disable iff (rst) !(tap_vld && !accept && !flush && (inflight_q == '0)));

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (FCNT_W)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (tap_data),
        .pop_i       (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .count_o     (fifo_count)
    );

    assign cfg_busy = cfg_busy_q;
    assign cur_lat  = cur_lat_q;
    assign inflight = inflight_q;

endmodule

// File: doc/delay_sched_ctrl.md
Name: delay_sched_ctrl

Overview:
- Scheduler wrapping a variable-tap delay line so fixed-latency units (multiplier, CSR shadow, timing-matched sidebands) can be modelled under valid/ready flow control.
- Upstream pushes data items; each emerges after a programmable latency into a small output FIFO.
- Credit logic admits an item only if output space is guaranteed, because the delay line itself never stalls.
- Also provides flush of in-flight items and safe run-time latency reconfiguration.

Parameters:
- DATA_WIDTH, 16, payload width.
- MAX_LAT, 32, maximum delay-line stages; legal latency range 1..MAX_LAT.
- DEF_LAT, 4, latency loaded at reset.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, >=2.
- LAT_W, clog2(MAX_LAT+1), derived; width of latency fields.
- CNT_W, clog2(MAX_LAT+FIFO_DEPTH+1), derived; width of the in-flight counter.

Ports:
- clk  in  1  master clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream item valid.
- in_ready  out  1  upstream may transfer; item accepted when in_valid & in_ready.
- in_data  in  DATA_WIDTH  upstream payload.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream pop; pop when out_valid & out_ready.
- out_data  out  DATA_WIDTH  FIFO head payload.
- flush  in  1  kill all items still in the delay line.
- cfg_lat_we  in  1  request latency change.
- cfg_lat  in  LAT_W  requested latency.
- cfg_busy  out  1  latency change pending.
- cur_lat  out  LAT_W  latency currently in effect.
- inflight  out  CNT_W  items currently in the delay line.

Behaviour:
- Reset (async assert, sync use after deassert):
  - All stage valid bits 0; inflight 0; FIFO empty; out_valid 0; out_data 0.
  - cur_lat = DEF_LAT; cfg_busy 0; in_ready 0 while rst is high.
- Delay line:
  - MAX_LAT stages of {valid, data}, shifted every cycle unconditionally.
  - Stage0 <= accepted item, or valid=0 if no accept.
  - Tap = stage[cur_lat-1]. A valid tap is pushed into the FIFO at the same edge.
- Latency:
  - Item accepted in cycle 0 occupies stage k in cycle k+1 and reaches the tap in cycle cur_lat.
  - It enters the FIFO at the end of cycle cur_lat.
  - With an empty FIFO, out_valid rises in cycle cur_lat+1. No FIFO bypass.
- Credits: credit = FIFO_DEPTH - fifo_count - inflight.
- in_ready = (credit > 0) & !flush & !cfg_busy & !rst. It is a function of registered state only; it never depends on in_valid or out_ready.
- A pop in the current cycle does not add credit until the next cycle.
- inflight update:
  - +1 on accept, -1 on valid tap push; simultaneous accept and push leaves it unchanged.
  - Must never exceed MAX_LAT+FIFO_DEPTH or underflow.
- FIFO:
  - Push and pop in the same cycle are legal, including when full or empty-with-push.
  - The credit scheme guarantees no push into a full FIFO; assertion fires otherwise.
  - out_data is registered from the head entry and holds while out_valid & !out_ready.
- Flush:
  - In the flush cycle all stage valids are cleared and inflight is set to 0.
  - A valid tap in that cycle is discarded and in_ready is 0.
  - FIFO contents are kept (completed results) and popping continues normally.
- Reconfiguration:
  - cfg_lat_we latches the value into a pending register and sets cfg_busy. A later cfg_lat_we overwrites the pending value.
  - cfg_lat=0 is clamped to 1; values >MAX_LAT are clamped to MAX_LAT.
  - The pending value is applied at the first edge where inflight==0; cfg_busy clears at that edge and in_ready may rise the following cycle.
  - With inflight==0 already, it is applied at the next edge (one cycle busy).
  - Flush together with a pending cfg: the flush zeroes inflight, so the cfg is applied at the next edge.
  - The FIFO need not be empty for a latency change.
- Simultaneous events: flush and cfg_lat_we in the same cycle are both honoured. rst overrides everything, mid-flight included; all in-flight and FIFO items are lost.

Decomposition:
- Shared package/header delay_sched_pkg:
  - Latency clamp function.
  - LAT_W/CNT_W width helper (clog2).
  - DEF_LAT default.
- One natural sub-module: sync_fifo (DATA_WIDTH, FIFO_DEPTH).
  - Registered head, count output, async active-high rst.
  - Reused later by other pipeline blocks.
- Delay line and credit/cfg logic stay in delay_sched_ctrl.

Test Plan:
- Single item: reset, cur_lat=4, push 0x1234 in cycle 0, out_ready=1 -> out_valid=1 with out_data=0x1234 in cycle 5 only; inflight 1 during cycles 1-4, then 0.
- Backpressure: out_ready=0, FIFO_DEPTH=4, lat=4, in_valid held high -> exactly 4 items accepted, then in_ready=0. Raise out_ready -> items 0..3 drain in order, with no loss and no overflow assertion.
- Streaming: lat=1, in_valid and out_ready always 1, data 0..99 -> full throughput, each output 2 cycles after its accept, in order.
- Flush: lat=8, accept items A,B,C in 3 consecutive cycles, flush 2 cycles later -> none emerge. Items already in the FIFO still pop, inflight=0 after flush, in_ready returns the next cycle.
- Reconfig: 3 items in flight at lat=6, cfg_lat_we with 10 -> cfg_busy until the last item exits, in_ready low meanwhile. Then cur_lat=10, and the next item appears 11 cycles after accept. cfg_lat=0 -> cur_lat=1; cfg_lat=40 -> 32.
- Reset mid-operation: assert rst asynchronously with FIFO half full and inflight=3 -> out_valid, inflight and cfg_busy drop immediately, cur_lat=DEF_LAT. No stale item is ever output after release.
